// File: rtl/muldiv_pkg.sv
// Shared encodings for the iterative M-extension multiply/divide unit.
package muldiv_pkg;

   localparam logic [2:0] F3_MUL    = 3'b000;
   localparam logic [2:0] F3_MULH   = 3'b001;
   localparam logic [2:0] F3_MULHSU = 3'b010;
   localparam logic [2:0] F3_MULHU  = 3'b011;
   localparam logic [2:0] F3_DIV    = 3'b100;
   localparam logic [2:0] F3_DIVU   = 3'b101;
   localparam logic [2:0] F3_REM    = 3'b110;
   localparam logic [2:0] F3_REMU   = 3'b111;

   typedef enum logic [1:0] {
      StIdle = 2'b00,
      StCalc = 2'b01,
      StFix  = 2'b10,
      StDone = 2'b11
   } state_e;

   typedef enum logic [1:0] {
      OpMulLo = 2'b00,
      OpMulHi = 2'b01,
      OpDivQ  = 2'b10,
      OpDivR  = 2'b11
   } op_e;

endpackage

// File: rtl/muldiv_decoder.sv
// Maps funct3 to operation class and per-operand signedness.
module muldiv_decoder
   import muldiv_pkg::*;
(
   input  logic [2:0] funct3_i,
   output op_e        op_o,
   output logic       a_signed_o,
   output logic       b_signed_o
);

   always_comb begin
      op_o       = OpMulLo;
      a_signed_o = 1'b0;
      b_signed_o = 1'b0;
      unique case (funct3_i)
         F3_MUL: begin
            op_o = OpMulLo;
         end
         F3_MULH: begin
            op_o       = OpMulHi;
            a_signed_o = 1'b1;
            b_signed_o = 1'b1;
         end
         F3_MULHSU: begin
            op_o       = OpMulHi;
            a_signed_o = 1'b1;
         end
         F3_MULHU: begin
            op_o = OpMulHi;
         end
         F3_DIV: begin
            op_o       = OpDivQ;
            a_signed_o = 1'b1;
            b_signed_o = 1'b1;
         end
         F3_DIVU: begin
            op_o = OpDivQ;
         end
         F3_REM: begin
            op_o       = OpDivR;
            a_signed_o = 1'b1;
            b_signed_o = 1'b1;
         end
         F3_REMU: begin
            op_o = OpDivR;
         end
         default: begin
            op_o = OpMulLo;
         end
      endcase
   end

endmodule

// File: rtl/muldiv_unit.sv
// Iterative multiply/divide unit: one bit per cycle on operand magnitudes, sign fix at the end.
module muldiv_unit
   import muldiv_pkg::*;
#(
   parameter int unsigned XLEN = 32
) (
   input  logic            clk,
   input  logic            reset,
   input  logic            start,
   input  logic            kill,
   input  logic [2:0]      funct3,
   input  logic [XLEN-1:0] a,
   input  logic [XLEN-1:0] b,
   output logic            busy,
   output logic            done,
   output logic [XLEN-1:0] result
);

   localparam int unsigned CntW = $clog2(XLEN);

   state_e            state_q, state_d;
   op_e               op_q, op_d;
   logic [CntW-1:0]   count_q, count_d;
   logic [XLEN-1:0]   hi_q, hi_d;
   logic [XLEN-1:0]   lo_q, lo_d;
   logic [XLEN-1:0]   opb_q, opb_d;
   logic [XLEN-1:0]   a_q, a_d;
   logic              a_neg_q, a_neg_d;
   logic              b_neg_q, b_neg_d;
   logic              b_zero_q, b_zero_d;
   logic [XLEN-1:0]   result_q, result_d;

   op_e               dec_op;
   logic              dec_a_signed;
   logic              dec_b_signed;

   muldiv_decoder u_decoder (
      .funct3_i   (funct3),
      .op_o       (dec_op),
      .a_signed_o (dec_a_signed),
      .b_signed_o (dec_b_signed)
   );

   logic              in_a_neg, in_b_neg, in_is_div;
   logic [XLEN-1:0]   in_a_mag, in_b_mag;

   assign in_a_neg  = dec_a_signed & a[XLEN-1];
   assign in_b_neg  = dec_b_signed & b[XLEN-1];
   assign in_a_mag  = in_a_neg ? (~a + 1'b1) : a;
   assign in_b_mag  = in_b_neg ? (~b + 1'b1) : b;
   assign in_is_div = (dec_op == OpDivQ) || (dec_op == OpDivR);

   logic              is_div;
   logic [XLEN:0]     mul_sum;
   logic [XLEN:0]     div_shift;
   logic [XLEN:0]     div_diff;
   logic              div_ok;

   assign is_div    = (op_q == OpDivQ) || (op_q == OpDivR);
   // Multiply: hi accumulates, lo holds the multiplier and shifts out its used bits.
   assign mul_sum   = {1'b0, hi_q} + (lo_q[0] ? {1'b0, opb_q} : '0);
   // Divide: hi is the partial remainder, lo shifts dividend bits out and quotient bits in.
   assign div_shift = {hi_q, lo_q[XLEN-1]};
   assign div_diff  = div_shift - {1'b0, opb_q};
   assign div_ok    = ~div_diff[XLEN];

   logic [2*XLEN-1:0] product, prod_fix;
   logic [XLEN-1:0]   quot_fix, rem_fix, fix_val;

   assign product  = {hi_q, lo_q};
   assign prod_fix = (a_neg_q ^ b_neg_q) ? (~product + 1'b1) : product;

   always_comb begin
      quot_fix = lo_q;
      rem_fix  = hi_q;
      if (b_zero_q) begin
         quot_fix = '1;
         rem_fix  = a_q;
      end else begin
         if (a_neg_q ^ b_neg_q) quot_fix = ~lo_q + 1'b1;
         if (a_neg_q)           rem_fix  = ~hi_q + 1'b1;
      end
   end

   always_comb begin
      fix_val = prod_fix[XLEN-1:0];
      unique case (op_q)
         OpMulLo: fix_val = prod_fix[XLEN-1:0];
         OpMulHi: fix_val = prod_fix[2*XLEN-1:XLEN];
         OpDivQ:  fix_val = quot_fix;
         OpDivR:  fix_val = rem_fix;
         default: fix_val = prod_fix[XLEN-1:0];
      endcase
   end

   always_comb begin
      state_d  = state_q;
      op_d     = op_q;
      count_d  = count_q;
      hi_d     = hi_q;
      lo_d     = lo_q;
      opb_d    = opb_q;
      a_d      = a_q;
      a_neg_d  = a_neg_q;
      b_neg_d  = b_neg_q;
      b_zero_d = b_zero_q;
      result_d = result_q;

      unique case (state_q)
         StIdle: begin
            if (start && !kill) begin
               state_d  = StCalc;
               count_d  = CntW'(XLEN - 1);
               op_d     = dec_op;
               a_d      = a;
               a_neg_d  = in_a_neg;
               b_neg_d  = in_b_neg;
               b_zero_d = (b == '0);
               hi_d     = '0;
               lo_d     = in_is_div ? in_a_mag : in_b_mag;
               opb_d    = in_is_div ? in_b_mag : in_a_mag;
            end
         end
         StCalc: begin
            if (kill) begin
               state_d = StIdle;
            end else begin
               if (is_div) begin
                  hi_d = div_ok ? div_diff[XLEN-1:0] : div_shift[XLEN-1:0];
                  lo_d = {lo_q[XLEN-2:0], div_ok};
               end else begin
                  hi_d = mul_sum[XLEN:1];
                  lo_d = {mul_sum[0], lo_q[XLEN-1:1]};
               end
               if (count_q == '0) begin
                  state_d = StFix;
               end else begin
                  count_d = count_q - 1'b1;
               end
            end
         end
         StFix: begin
            if (kill) begin
               state_d = StIdle;
            end else begin
               state_d  = StDone;
               result_d = fix_val;
            end
         end
         StDone: begin
            state_d = StIdle;
         end
         default: begin
            state_d = StIdle;
         end
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q  <= StIdle;
         op_q     <= OpMulLo;
         count_q  <= '0;
         hi_q     <= '0;
         lo_q     <= '0;
         opb_q    <= '0;
         a_q      <= '0;
         a_neg_q  <= 1'b0;
         b_neg_q  <= 1'b0;
         b_zero_q <= 1'b0;
         result_q <= '0;
      end else begin
         state_q  <= state_d;
         op_q     <= op_d;
         count_q  <= count_d;
         hi_q     <= hi_d;
         lo_q     <= lo_d;
         opb_q    <= opb_d;
         a_q      <= a_d;
         a_neg_q  <= a_neg_d;
         b_neg_q  <= b_neg_d;
         b_zero_q <= b_zero_d;
         result_q <= result_d;
      end
   end

   assign busy   = (state_q != StIdle);
   assign done   = (state_q == StDone);
   assign result = result_q;

endmodule

// File: tb/tb_muldiv_unit.sv
// Self-checking bench for muldiv_unit: directed corner cases, handshake, reset and random ops.
module tb_muldiv_unit;

   localparam int unsigned XLEN = 32;

   logic              clk = 1'b0;
   logic              reset;
   logic              start;
   logic              kill;
   logic [2:0]        funct3;
   logic [XLEN-1:0]   a;
   logic [XLEN-1:0]   b;
   logic              busy;
   logic              done;
   logic [XLEN-1:0]   result;

   int n_checks = 0;
   int n_errors = 0;
   int cyc      = 0;
   int t_acc    = 0;
   logic [31:0] last_exp = '0;

   muldiv_unit #(.XLEN(XLEN)) dut (
      .clk    (clk),
      .reset  (reset),
      .start  (start),
      .kill   (kill),
      .funct3 (funct3),
      .a      (a),
      .b      (b),
      .busy   (busy),
      .done   (done),
      .result (result)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   // Reference semantics of the RISC-V M extension, using wide native arithmetic.
   function automatic logic [31:0] ref_model(input logic [2:0] f3, input logic [31:0] av,
                                             input logic [31:0] bv);
      longint sa, sb, ua, ub;
      logic [63:0] p;
      int ia, ib;
      sa = longint'($signed(av));
      sb = longint'($signed(bv));
      ua = longint'({32'b0, av});
      ub = longint'({32'b0, bv});
      ia = $signed(av);
      ib = $signed(bv);
      case (f3)
         3'd0: begin p = 64'(ua * ub); return p[31:0]; end
         3'd1: begin p = 64'(sa * sb); return p[63:32]; end
         3'd2: begin p = 64'(sa * ub); return p[63:32]; end
         3'd3: begin p = 64'(ua * ub); return p[63:32]; end
         3'd4: begin
            if (bv == 0) return 32'hFFFF_FFFF;
            if (av == 32'h8000_0000 && bv == 32'hFFFF_FFFF) return av;
            return 32'(ia / ib);
         end
         3'd5: begin
            if (bv == 0) return 32'hFFFF_FFFF;
            return av / bv;
         end
         3'd6: begin
            if (bv == 0) return av;
            if (av == 32'h8000_0000 && bv == 32'hFFFF_FFFF) return 32'h0;
            return 32'(ia % ib);
         end
         default: begin
            if (bv == 0) return av;
            return av % bv;
         end
      endcase
   endfunction

   // Holds start until the unit is idle, then records the accepting edge in t_acc.
   task automatic issue(input logic [2:0] f3, input logic [31:0] av, input logic [31:0] bv);
      bit ok = 1'b0;
      for (int i = 0; i < 100; i++) begin
         @(negedge clk);
         start  = 1'b1;
         funct3 = f3;
         a      = av;
         b      = bv;
         if (!busy) begin
            ok = 1'b1;
            break;
         end
      end
      @(posedge clk);
      #1;
      start = 1'b0;
      t_acc = cyc;
      if (!ok) check("issue_timeout", 32'd0, 32'd1);
   endtask

   // Latency counts the first cycle after the accepting edge as cycle 1.
   task automatic wait_done(output logic [31:0] res, output int lat, output int done_cyc);
      int busy_lo = 0;
      bit seen = 1'b0;
      check("busy_rise", 32'(busy), 32'd1);
      for (int i = 0; i < 80; i++) begin
         if (done) begin
            seen = 1'b1;
            break;
         end
         if (!busy) busy_lo++;
         @(posedge clk);
         #1;
      end
      res      = result;
      lat      = cyc - t_acc + 1;
      done_cyc = cyc;
      if (!seen) check("done_timeout", 32'd0, 32'd1);
      check("busy_gap", 32'(busy_lo), 32'd0);
   endtask

   task automatic run_op(input string tag, input logic [2:0] f3, input logic [31:0] av,
                         input logic [31:0] bv, input logic [31:0] exp);
      logic [31:0] res;
      int lat, dc;
      issue(f3, av, bv);
      wait_done(res, lat, dc);
      check(tag, res, exp);
      check({tag, "_lat"}, 32'(lat), 32'd34);
      last_exp = exp;
      @(posedge clk);
      #1;
      check({tag, "_busy_fall"}, {31'b0, busy} | {30'b0, done, 1'b0}, 32'd0);
   endtask

   task automatic count_done(input int n, output int pulses);
      pulses = 0;
      for (int i = 0; i < n; i++) begin
         @(posedge clk);
         #1;
         if (done) pulses++;
      end
   endtask

   typedef struct {
      logic [2:0]  f3;
      logic [31:0] av;
      logic [31:0] bv;
      logic [31:0] exp;
   } vec_t;

   vec_t vecs[13];

   initial begin
      logic [31:0] res, res2, av, bv;
      logic [2:0]  f3;
      int lat, d1, d2, pulses, sel;

      vecs[0]  = '{3'd0, 32'd7,          32'hFFFF_FFFD, 32'hFFFF_FFEB};
      vecs[1]  = '{3'd1, 32'h8000_0000,  32'h8000_0000, 32'h4000_0000};
      vecs[2]  = '{3'd3, 32'hFFFF_FFFF,  32'hFFFF_FFFF, 32'hFFFF_FFFE};
      vecs[3]  = '{3'd2, 32'hFFFF_FFFF,  32'hFFFF_FFFF, 32'hFFFF_FFFF};
      vecs[4]  = '{3'd4, 32'hFFFF_FFF9,  32'd2,         32'hFFFF_FFFD};
      vecs[5]  = '{3'd6, 32'hFFFF_FFF9,  32'd2,         32'hFFFF_FFFF};
      vecs[6]  = '{3'd5, 32'd100,        32'd7,         32'd14};
      vecs[7]  = '{3'd7, 32'd100,        32'd7,         32'd2};
      vecs[8]  = '{3'd5, 32'd5,          32'd0,         32'hFFFF_FFFF};
      vecs[9]  = '{3'd6, 32'hFFFF_FFF9,  32'd0,         32'hFFFF_FFF9};
      vecs[10] = '{3'd4, 32'h8000_0000,  32'hFFFF_FFFF, 32'h8000_0000};
      vecs[11] = '{3'd6, 32'h8000_0000,  32'hFFFF_FFFF, 32'h0};
      vecs[12] = '{3'd7, 32'd9,          32'd0,         32'd9};

      reset  = 1'b1;
      start  = 1'b0;
      kill   = 1'b0;
      funct3 = '0;
      a      = '0;
      b      = '0;
      repeat (3) @(posedge clk);
      #1;
      check("rst_busy", 32'(busy), 32'd0);
      check("rst_done", 32'(done), 32'd0);
      check("rst_result", result, 32'd0);
      @(negedge clk);
      reset = 1'b0;

      foreach (vecs[i]) begin
         run_op($sformatf("dir%0d", i), vecs[i].f3, vecs[i].av, vecs[i].bv, vecs[i].exp);
      end

      // start and kill together while idle must not launch an operation
      @(negedge clk);
      start = 1'b1;
      kill  = 1'b1;
      @(posedge clk);
      #1;
      start = 1'b0;
      kill  = 1'b0;
      check("start_kill_idle", 32'(busy), 32'd0);

      // a second start mid-flight is dropped
      issue(3'd0, 32'd6, 32'd7);
      repeat (4) begin
         @(posedge clk);
         #1;
      end
      start  = 1'b1;
      funct3 = 3'd5;
      a      = 32'd1000;
      b      = 32'd3;
      @(posedge clk);
      #1;
      start = 1'b0;
      wait_done(res, lat, d1);
      check("ignore_start_res", res, 32'd42);
      check("ignore_start_lat", 32'(lat), 32'd34);
      last_exp = 32'd42;
      count_done(40, pulses);
      check("ignore_start_one_done", 32'(pulses), 32'd0);

      // kill mid-calculation
      issue(3'd4, 32'd1234, 32'd5);
      repeat (9) begin
         @(posedge clk);
         #1;
      end
      kill = 1'b1;
      @(posedge clk);
      #1;
      kill = 1'b0;
      check("kill_idle", 32'(busy), 32'd0);
      count_done(40, pulses);
      check("kill_no_done", 32'(pulses), 32'd0);
      check("kill_result_kept", result, last_exp);

      // asynchronous reset mid-operation
      issue(3'd3, 32'hDEAD_BEEF, 32'h1234_5678);
      repeat (19) begin
         @(posedge clk);
         #1;
      end
      #2;
      reset = 1'b1;
      #1;
      check("midrst_busy", 32'(busy), 32'd0);
      check("midrst_done", 32'(done), 32'd0);
      check("midrst_result", result, 32'd0);
      @(negedge clk);
      reset = 1'b0;
      run_op("post_rst_divu", 3'd5, 32'd100, 32'd7, 32'd14);

      // back-to-back issue right after DONE
      issue(3'd1, 32'hFFFF_FFFE, 32'd3);
      wait_done(res, lat, d1);
      issue(3'd7, 32'd1000, 32'd33);
      wait_done(res2, lat, d2);
      check("b2b_first", res, ref_model(3'd1, 32'hFFFF_FFFE, 32'd3));
      check("b2b_second", res2, 32'd10);
      check("b2b_spacing", 32'(d2 - d1), 32'd35);
      @(posedge clk);
      #1;

      for (int i = 0; i < 40; i++) begin
         f3  = 3'($urandom_range(0, 7));
         sel = $urandom_range(0, 7);
         av  = (sel == 0) ? 32'h8000_0000 : (sel == 1) ? 32'd0 :
               (sel == 2) ? 32'($urandom_range(0, 100)) : 32'($urandom);
         sel = $urandom_range(0, 7);
         bv  = (sel == 0) ? 32'd0 : (sel == 1) ? 32'hFFFF_FFFF :
               (sel == 2) ? 32'($urandom_range(1, 15)) : 32'($urandom);
         run_op($sformatf("rnd%0d_f%0d", i, f3), f3, av, bv, ref_model(f3, av, bv));
      end

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
